// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FWFT FIFO family.
// Defaults here size the systolic-array staging FIFOs unless overridden.
package fifo_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 8;
  localparam int unsigned DEF_FIFO_CAP   = 16;

  // Bits needed to index 'value' distinct states; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping index 0..FIFO_CAP-1 with a phase bit that toggles on each wrap,
// so two pointers can distinguish full from empty at equal indices.
module fifo_wrap_ptr #(
  parameter int unsigned FIFO_CAP  = 16,
  parameter int unsigned PTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] ptr,
  output logic                 phase
);

  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(FIFO_CAP - 1);

  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic                 phase_q, phase_d;

  always_comb begin
    ptr_d   = ptr_q;
    phase_d = phase_q;
    if (clear) begin
      ptr_d   = '0;
      phase_d = 1'b0;
    end else if (inc) begin
      if (ptr_q == LAST_IDX) begin
        ptr_d   = '0;
        phase_d = ~phase_q;
      end else begin
        ptr_d = ptr_q + PTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
    end
  end

  assign ptr   = ptr_q;
  assign phase = phase_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with arbitrary depth, occupancy
// count, almost-full/empty thresholds, flush and sticky error flags.
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter  int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter  int unsigned FIFO_CAP   = DEF_FIFO_CAP,
  parameter  int unsigned AF_LEVEL   = FIFO_CAP - 2,
  parameter  int unsigned AE_LEVEL   = 2,
  localparam int unsigned PTR_WIDTH  = clog2(FIFO_CAP),
  localparam int unsigned CNT_WIDTH  = clog2(FIFO_CAP + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  w_enable,
  input  logic [WORD_WIDTH-1:0] d_in,
  input  logic                  r_enable,
  output logic [WORD_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [PTR_WIDTH-1:0]  w_ptr, r_ptr;
  logic                  w_phase, r_phase;
  logic                  ptr_equal, full_int, empty_int;
  logic                  rd_acc, wr_acc;

  logic [WORD_WIDTH-1:0] mem_q [FIFO_CAP];
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [31:0]           count_ext;

  assign ptr_equal = (w_ptr == r_ptr);
  assign empty_int = ptr_equal && (w_phase == r_phase);
  assign full_int  = ptr_equal && (w_phase != r_phase);

  // A read on a full FIFO frees the head slot, so the write can reuse it.
  assign rd_acc = r_enable && !empty_int;
  assign wr_acc = w_enable && (!full_int || rd_acc);

  fifo_wrap_ptr #(
    .FIFO_CAP (FIFO_CAP),
    .PTR_WIDTH(PTR_WIDTH)
  ) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .clear(flush),
    .inc  (wr_acc && !flush),
    .ptr  (w_ptr),
    .phase(w_phase)
  );

  fifo_wrap_ptr #(
    .FIFO_CAP (FIFO_CAP),
    .PTR_WIDTH(PTR_WIDTH)
  ) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .clear(flush),
    .inc  (rd_acc && !flush),
    .ptr  (r_ptr),
    .phase(r_phase)
  );

  always_ff @(posedge clk) begin
    if (wr_acc && !flush && !reset) begin
      mem_q[w_ptr] <= d_in;
    end
  end

  // Flush cycles ignore requests entirely, including their error side effects.
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
      if (w_enable && !wr_acc) overflow_d = 1'b1;
      if (r_enable && !rd_acc) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_ext    = 32'(count_q);
  assign d_out        = empty_int ? '0 : mem_q[r_ptr];
  assign full         = full_int;
  assign empty        = empty_int;
  assign almost_full  = (count_ext >= AF_LEVEL);
  assign almost_empty = (count_ext <= AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Drives a 16-deep and a 5-deep FIFO with identical stimulus and checks both
// against queue-based reference models after every clock edge.
module tb_fifo_sync_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, flush, w_enable, r_enable;
  logic [7:0] d_in;

  logic [7:0] dout16, dout5;
  logic       full16, empty16, af16, ae16, ovf16, unf16;
  logic       full5, empty5, af5, ae5, ovf5, unf5;
  logic [4:0] count16;
  logic [2:0] count5;

  fifo_sync_fwft #(.WORD_WIDTH(8), .FIFO_CAP(16)) u_dut16 (
    .clk(clk), .reset(reset), .flush(flush), .w_enable(w_enable), .d_in(d_in),
    .r_enable(r_enable), .d_out(dout16), .full(full16), .empty(empty16),
    .almost_full(af16), .almost_empty(ae16), .count(count16),
    .overflow(ovf16), .underflow(unf16)
  );

  fifo_sync_fwft #(.WORD_WIDTH(8), .FIFO_CAP(5)) u_dut5 (
    .clk(clk), .reset(reset), .flush(flush), .w_enable(w_enable), .d_in(d_in),
    .r_enable(r_enable), .d_out(dout5), .full(full5), .empty(empty5),
    .almost_full(af5), .almost_empty(ae5), .count(count5),
    .overflow(ovf5), .underflow(unf5)
  );

  logic [31:0] obs_dout[2], obs_cnt[2];
  logic        obs_full[2], obs_empty[2], obs_af[2], obs_ae[2], obs_ovf[2], obs_unf[2];
  assign obs_dout[0] = 32'(dout16);   assign obs_dout[1] = 32'(dout5);
  assign obs_cnt[0]  = 32'(count16);  assign obs_cnt[1]  = 32'(count5);
  assign obs_full[0] = full16;        assign obs_full[1] = full5;
  assign obs_empty[0] = empty16;      assign obs_empty[1] = empty5;
  assign obs_af[0]   = af16;          assign obs_af[1]   = af5;
  assign obs_ae[0]   = ae16;          assign obs_ae[1]   = ae5;
  assign obs_ovf[0]  = ovf16;         assign obs_ovf[1]  = ovf5;
  assign obs_unf[0]  = unf16;         assign obs_unf[1]  = unf5;

  // Reference model: an ordinary queue with capacity and sticky error bits.
  logic [7:0] mq [2][$];
  bit         m_ovf[2], m_unf[2];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;

  function automatic int cap_of(input int m);
    return (m == 0) ? 16 : 5;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit we, input logic [7:0] din, input bit re);
    reset = rst; flush = fl; w_enable = we; d_in = din; r_enable = re;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      bit ra, wa;
      if (rst) begin
        mq[m].delete(); m_ovf[m] = 0; m_unf[m] = 0;
      end else if (fl) begin
        mq[m].delete();
      end else begin
        ra = re && (mq[m].size() > 0);
        wa = we && ((mq[m].size() < cap_of(m)) || ra);
        if (ra) void'(mq[m].pop_front());
        if (wa) mq[m].push_back(din);
        if (we && !wa) m_ovf[m] = 1;
        if (re && !ra) m_unf[m] = 1;
      end
    end
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      int n, c;
      string s;
      n = mq[m].size();
      c = cap_of(m);
      s = $sformatf("c%0d", c);
      check_eq({"dout_", s}, obs_dout[m], (n > 0) ? 32'(mq[m][0]) : 32'd0);
      check_eq({"count_", s}, obs_cnt[m], 32'(n));
      check_eq({"full_", s}, 32'(obs_full[m]), 32'(n == c));
      check_eq({"empty_", s}, 32'(obs_empty[m]), 32'(n == 0));
      check_eq({"afull_", s}, 32'(obs_af[m]), 32'(n >= c - 2));
      check_eq({"aempty_", s}, 32'(obs_ae[m]), 32'(n <= 2));
      check_eq({"ovf_", s}, 32'(obs_ovf[m]), 32'(m_ovf[m]));
      check_eq({"unf_", s}, 32'(obs_unf[m]), 32'(m_unf[m]));
    end
    $display("[TB] cyc=%0d rst=%0d fl=%0d we=%0d din=%02h re=%0d | c16=%0d c5=%0d",
             cyc, rst, fl, we, din, re, count16, count5);
  endtask

  initial begin
    logic [7:0] d;
    int wp, rp;

    // Reset, then idle.
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h99, 1);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    // Fill with 0x01..0x10, one extra write overflows, then drain in order.
    for (int i = 1; i <= 16; i++) step(0, 0, 1, 8'(i), 0);
    step(0, 0, 1, 8'hAA, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 8'h00, 1);

    // 3 writes / 3 reads, four rounds: wraps the 5-deep pointers.
    step(1, 0, 0, 8'h00, 0);
    d = 8'h10;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin step(0, 0, 1, d, 0); d++; end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
    end

    // Fill, then simultaneous read+write while full.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h40 + i), 1);

    // Read+write on empty, then flush at count 7.
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h3C, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'h50 + i), 0);
    step(0, 1, 1, 8'h55, 1);
    step(0, 0, 0, 8'h00, 0);

    // Reset mid-stream with both enables high.
    for (int i = 0; i < 9; i++) step(0, 0, 1, 8'(8'h60 + i), 0);
    step(1, 0, 1, 8'h77, 1);
    step(0, 0, 0, 8'h00, 0);

    // Random traffic with shifting write/read bias and rare flush/reset.
    wp = 50; rp = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        wp = 20 + 30 * $urandom_range(0, 2);
        rp = 20 + 30 * $urandom_range(0, 2);
      end
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < wp,
           8'($urandom),
           $urandom_range(0, 99) < rp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
- Parametrised synchronous first-word-fall-through FIFO for the systolic-array data path, e.g. input/weight staging and output drain.
- Next generation of the team's basic FIFO. Adds:
  - arbitrary (non-power-of-two) depth;
  - simultaneous read and write in one cycle;
  - occupancy count and programmable almost-full/almost-empty thresholds;
  - synchronous flush;
  - sticky overflow/underflow error flags.

Parameters:
- WORD_WIDTH, 8, data word width in bits (>=1)
- FIFO_CAP, 16, number of storage entries (>=2, any integer)
- AF_LEVEL, FIFO_CAP-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- PTR_WIDTH, $clog2(FIFO_CAP), derived (localparam), pointer width
- CNT_WIDTH, $clog2(FIFO_CAP+1), derived (localparam), count width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents; does not clear error flags
- w_enable  in  1  write request
- d_in  in  WORD_WIDTH  write data
- r_enable  in  1  read request; pops the word currently on d_out
- d_out  out  WORD_WIDTH  head word, valid whenever !empty (fall-through)
- full  out  1  count == FIFO_CAP
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CNT_WIDTH  current occupancy
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was dropped

Behaviour:
- Reset (reset=1 at the clock edge): pointers, phases, count and error flags go to 0.
  - Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), count=0, d_out=0.
  - Storage is not reset.
  - Reset has priority over flush and over any request in the same cycle.
- Pointers: w_ptr and r_ptr run 0..FIFO_CAP-1, each with a phase bit.
  - Increment wraps FIFO_CAP-1 -> 0 and toggles the phase.
  - Each accepted operation advances its pointer by exactly 1.
- full/empty: derived from pointer equality plus phase.
  - Equal pointers, different phase = full.
  - Equal pointers, same phase = empty.
  - count is a registered counter and must always agree with the pointer state.
- d_out is combinational from storage[r_ptr] and forced to 0 while empty. Read latency is zero: data is present before r_enable.
- Read acceptance: rd_acc = r_enable && !empty.
- Write acceptance: wr_acc = w_enable && (!full || rd_acc).
  - When full, a simultaneous read frees the slot, so both are accepted.
  - Data at the old head is consumed in that same cycle; the new word lands in the same index.
- Empty with both w_enable and r_enable: the write is accepted, the read is dropped (no bypass), and underflow is set.
- Count update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged when both or neither are accepted.
- Error flags:
  - overflow <= 1 when w_enable && !wr_acc;
  - underflow <= 1 when r_enable && !rd_acc;
  - both cleared only by reset.
- flush=1: pointers, phases and count go to 0 on the next edge. Any w_enable/r_enable in that cycle is ignored and does not set error flags.
- Thresholds are compared against registered count, so the almost flags are valid in the same cycle as count.

Decomposition:
- Shared package fifo_pkg holds:
  - clog2 helper function for PTR_WIDTH/CNT_WIDTH;
  - default FIFO_CAP/WORD_WIDTH constants used by the array top.
- Sub-module fifo_wrap_ptr: a wrapping pointer with phase bit. Parameters FIFO_CAP and PTR_WIDTH; inputs clk, reset, clear, inc; outputs ptr, phase. Instantiated twice, for write and read.
- Storage array, count and flags live in fifo_sync_fwft.

Test Plan:
- Reset then idle, FIFO_CAP=16 -> empty=1, full=0, count=0, d_out=0, almost_empty=1, overflow=underflow=0.
- Write 0x01..0x10 (16 words), then one extra write of 0xAA -> full=1 and count=16 after the 16th write; almost_full asserts at count=14; the 17th write is dropped and overflow=1. Reading back yields 0x01..0x10 in order.
- FIFO_CAP=5: 3 writes, 3 reads, repeated 4 times with incrementing data -> pointers wrap correctly through the non-power-of-two depth, data order is preserved, and count returns to 0.
- Fill to full, then assert w_enable+r_enable together for 5 cycles with new data -> full stays 1, count stays 16, each cycle pops the oldest word, and no overflow.
- Empty, then w_enable+r_enable with d_in=0x3C -> count=1, d_out=0x3C next cycle, underflow=1. Then flush with count=7 -> count=0, empty=1, and flags are unchanged.
- Reset asserted mid-stream with count=9 and both enables high -> next cycle count=0, empty=1, and error flags are cleared.
